stepper_profile_ctrl: RTL and testbench
=======================================

// Module: stepper_profile_ctrl
// PURPOSE
// Parametrised single-axis step/dir generator with trapezoidal acceleration and deceleration.
// Adds valid/ready command intake, homing against a limit switch, controlled abort, and status.
// Sits between the soft-CPU register map and the external stepper driver; one instance per axis.
// PARAMETERS
// POS_W       24      position / target width (two's-complement not used; unsigned, wraps mod 2^POS_W)
// DLY_W       21      step-interval counter width, in clk cycles
// PULSE_W     50      step high time, cycles (>=1)
// START_DELAY 15625   step interval at standstill / ramp start, cycles
// ACCEL_STEP  5       interval change per step while ramping, cycles
// HOME_DELAY  4096    fixed step interval during homing, cycles
// PORTS
// clk            in   1      clock
// reset          in   1      async, active-high
// cmd_valid      in   1      move command present
// cmd_ready      out  1      1 only in IDLE (combinational from state)
// cmd_target     in   POS_W  absolute goal position
// cmd_min_delay  in   DLY_W  cruise interval (sets top speed)
// home_req       in   1      start homing (level, sampled in IDLE)
// abort          in   1      request controlled stop
// limit_sw       in   1      home switch, async, 2-FF synchronised internally
// step           out  1      step pulse to driver
// dir            out  1      0 = position increments, 1 = decrements
// position       out  POS_W  current position
// busy           out  1      state != IDLE
// done           out  1      1-cycle pulse on return to IDLE (move, home or abort)
// homed          out  1      sticky, set by successful homing
// lim_fault      out  1      sticky, set on limit hit during MOVE; cleared on next accepted cmd
// BEHAVIOUR
// - Reset clock: clk. Reset: reset, asynchronous, active-high.
// - On reset: step=0, dir=0, position=0, busy=0, done=0, homed=0, lim_fault=0, state=IDLE,
//   interval=START_DELAY, ramp_cnt=0. Reset mid-move drops step immediately (truncated pulse allowed).
// - States: IDLE, MOVE, HOME, STOP (decelerating after abort).
// - IDLE: home_req has priority over cmd_valid. Command accepted on cmd_valid&&cmd_ready.
//   Accept latches target and min_delay. Clamp min_delay to [PULSE_W+1, START_DELAY].
//   Accept sets dir = (target < position).
//   If target==position: no step; done pulses next cycle; stay IDLE.
// - First step rises 2 cycles after accept, giving dir one cycle of setup.
//   Each step is high for PULSE_W cycles.
//   Consecutive rising edges are exactly `interval` cycles apart, where interval is the value
//   in force at the previous rising edge.
// - position +/-1 is registered in the same cycle step rises. dir never changes while busy.
// - Ramp update at each rising edge, with rem = |target - position_after_step|:
//   rem==0 -> finish. rem<=ramp_cnt -> interval+=ACCEL_STEP (saturate START_DELAY), ramp_cnt--.
//   else if interval>min_delay -> interval=max(interval-ACCEL_STEP, min_delay), ramp_cnt++.
//   else cruise.
// - Finish: wait for step low, then done=1 for 1 cycle, IDLE, interval=START_DELAY, ramp_cnt=0.
// - abort in MOVE -> STOP. STOP emits exactly ramp_cnt further steps, decelerating, then finishes.
//   abort in MOVE with ramp_cnt==0 -> no further steps.
//   abort in HOME -> finish immediately after the current pulse; homed unchanged.
//   abort in IDLE/STOP ignored.
// - HOME: dir=1, interval=HOME_DELAY, no ramp; steps until synced limit_sw==1.
//   Homing completes with position=0, homed=1, done pulse.
//   limit_sw already 1 on entry -> zero steps, same completion.
// - limit_sw==1 in MOVE/STOP with dir==1: no further steps, lim_fault=1, finish (done pulses).
//   position is kept, not zeroed.
// - home_req/cmd_valid while busy: ignored (cmd_ready=0).
// - Interval arithmetic is DLY_W wide and saturating.
//   Position arithmetic wraps mod 2^POS_W; rem uses unsigned magnitude.
// TESTING (bench params: START_DELAY=100, ACCEL_STEP=10, PULSE_W=5, HOME_DELAY=20)
// - Move 0->20, min_delay 60: intervals 100,90,80,70,60,60.. then 70,80,90,100.
//   Expect 20 steps, dir=0, position=20, single done pulse, busy low after.
// - Move 0->3, min_delay 60: triangular, intervals never <80.
//   Expect position=3 and no cruise segment.
// - Move 10->0: dir=1 two cycles before first step; position decrements to 0; done.
// - home_req with limit_sw raised after 7 steps (intervals 20):
//   Expect stop within 2 sync cycles of the next edge, position=0, homed=1, done.
// - Move 0->1000, abort at cruise with ramp_cnt=4:
//   Expect exactly 4 more steps at 70,80,90,100, then done; cmd_ready=1 after.
// - Reset asserted mid-pulse: step/busy/position all 0 asynchronously.
//   Next command at target==position -> done with no step.

Source files
------------

// File: rtl/stepper_profile_ctrl.sv
// Single-axis step/dir generator with trapezoidal ramping, homing against a limit switch,
// controlled abort and sticky status flags. One instance per axis.
module stepper_profile_ctrl #(
  parameter int POS_W       = 24,
  parameter int DLY_W       = 21,
  parameter int PULSE_W     = 50,
  parameter int START_DELAY = 15625,
  parameter int ACCEL_STEP  = 5,
  parameter int HOME_DELAY  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [DLY_W-1:0] cmd_min_delay,
  input  logic             home_req,
  input  logic             abort,
  input  logic             limit_sw,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             homed,
  output logic             lim_fault
);

  localparam int CMP_W = (POS_W > DLY_W) ? POS_W : DLY_W;
  localparam logic [DLY_W-1:0] START_D = DLY_W'(START_DELAY);
  localparam logic [DLY_W-1:0] HOME_D  = DLY_W'(HOME_DELAY);
  localparam logic [DLY_W-1:0] ACC_D   = DLY_W'(ACCEL_STEP);
  localparam logic [DLY_W-1:0] MIN_D   = DLY_W'(PULSE_W + 1);
  localparam logic [DLY_W-1:0] PW_D    = DLY_W'(PULSE_W - 1);
  localparam logic [DLY_W-1:0] ONE_D   = DLY_W'(1);
  localparam logic [POS_W-1:0] ONE_P   = POS_W'(1);

  typedef enum logic [1:0] {IDLE, MOVE, HOME, STOP} state_t;

  state_t           state_q, state_d;
  logic             step_q, step_d, dir_q, dir_d, done_q, done_d;
  logic             homed_q, homed_d, lim_fault_q, lim_fault_d, fin_q, fin_d;
  logic             lim_s1_q, lim_s1_d, lim_s2_q, lim_s2_d;
  logic [POS_W-1:0] position_q, position_d, target_q, target_d;
  logic [DLY_W-1:0] interval_q, interval_d, ramp_cnt_q, ramp_cnt_d;
  logic [DLY_W-1:0] cnt_q, cnt_d, pw_q, pw_d, min_q, min_d;
  logic [POS_W-1:0] pos_n, rem;
  logic [DLY_W-1:0] ivl_n;

  function automatic logic [DLY_W-1:0] ivl_up(input logic [DLY_W-1:0] i);
    logic [DLY_W:0] s;
    s = {1'b0, i} + {1'b0, ACC_D};
    if (s >= {1'b0, START_D}) return START_D;
    return s[DLY_W-1:0];
  endfunction

  function automatic logic [DLY_W-1:0] ivl_down(input logic [DLY_W-1:0] i,
                                                input logic [DLY_W-1:0] m);
    if ({1'b0, i} <= ({1'b0, m} + {1'b0, ACC_D})) return m;
    return i - ACC_D;
  endfunction

  function automatic logic [DLY_W-1:0] clamp_min(input logic [DLY_W-1:0] m);
    if (m < MIN_D) return MIN_D;
    if (m > START_D) return START_D;
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    homed_d     = homed_q;
    lim_fault_d = lim_fault_q;
    fin_d       = fin_q;
    position_d  = position_q;
    target_d    = target_q;
    min_d       = min_q;
    interval_d  = interval_q;
    ramp_cnt_d  = ramp_cnt_q;
    cnt_d       = cnt_q;
    pw_d        = pw_q;
    lim_s1_d    = limit_sw;
    lim_s2_d    = lim_s1_q;
    pos_n       = position_q;
    rem         = '0;
    ivl_n       = interval_q;

    if (step_q) begin
      if (pw_q == '0) step_d = 1'b0;
      else            pw_d   = pw_q - ONE_D;
    end
    if (cnt_q != '0) cnt_d = cnt_q - ONE_D;

    case (state_q)
      IDLE: begin
        if (home_req) begin
          state_d    = HOME;
          dir_d      = 1'b1;
          interval_d = HOME_D;
          cnt_d      = ONE_D;
        end else if (cmd_valid) begin
          lim_fault_d = 1'b0;
          target_d    = cmd_target;
          min_d       = clamp_min(cmd_min_delay);
          if (cmd_target == position_q) begin
            done_d = 1'b1;
          end else begin
            state_d = MOVE;
            dir_d   = (cmd_target < position_q);
            cnt_d   = ONE_D;  // one idle cycle of dir setup before the first edge
          end
        end
      end
      default: begin
        if (fin_q) begin
          if (!step_q) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            fin_d      = 1'b0;
            interval_d = START_D;
            ramp_cnt_d = '0;
          end
        end else if (state_q == HOME) begin
          if (lim_s2_q) begin
            position_d = '0;
            homed_d    = 1'b1;
            fin_d      = 1'b1;
          end else if (abort) begin
            fin_d = 1'b1;
          end else if (cnt_q == '0) begin
            step_d     = 1'b1;
            pw_d       = PW_D;
            position_d = position_q - ONE_P;
            cnt_d      = HOME_D - ONE_D;
          end
        end else if (dir_q && lim_s2_q) begin
          lim_fault_d = 1'b1;
          fin_d       = 1'b1;
        end else if (state_q == MOVE && abort) begin
          if (ramp_cnt_q == '0) fin_d = 1'b1;
          else                  state_d = STOP;
        end else if (cnt_q == '0) begin
          pos_n = dir_q ? position_q - ONE_P : position_q + ONE_P;
          rem   = dir_q ? pos_n - target_q : target_q - pos_n;
          step_d     = 1'b1;
          pw_d       = PW_D;
          position_d = pos_n;
          if (state_q == STOP) begin
            ivl_n      = ivl_up(interval_q);
            ramp_cnt_d = ramp_cnt_q - ONE_D;
            if (rem == '0 || ramp_cnt_q == ONE_D) fin_d = 1'b1;
          end else if (rem == '0) begin
            fin_d = 1'b1;
          end else if (CMP_W'(rem) <= CMP_W'(ramp_cnt_q)) begin
            ivl_n      = ivl_up(interval_q);
            ramp_cnt_d = ramp_cnt_q - ONE_D;
          end else if (interval_q > min_q) begin
            ivl_n      = ivl_down(interval_q, min_q);
            ramp_cnt_d = ramp_cnt_q + ONE_D;
          end
          interval_d = ivl_n;
          cnt_d      = ivl_n - ONE_D;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      homed_q     <= 1'b0;
      lim_fault_q <= 1'b0;
      fin_q       <= 1'b0;
      lim_s1_q    <= 1'b0;
      lim_s2_q    <= 1'b0;
      position_q  <= '0;
      interval_q  <= START_D;
      ramp_cnt_q  <= '0;
      cnt_q       <= '0;
      pw_q        <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      homed_q     <= homed_d;
      lim_fault_q <= lim_fault_d;
      fin_q       <= fin_d;
      lim_s1_q    <= lim_s1_d;
      lim_s2_q    <= lim_s2_d;
      position_q  <= position_d;
      interval_q  <= interval_d;
      ramp_cnt_q  <= ramp_cnt_d;
      cnt_q       <= cnt_d;
      pw_q        <= pw_d;
    end
  end

  // Command operands are only meaningful once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    target_q <= target_d;
    min_q    <= min_d;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign step      = step_q;
  assign dir       = dir_q;
  assign position  = position_q;
  assign done      = done_q;
  assign homed     = homed_q;
  assign lim_fault = lim_fault_q;

endmodule

// File: tb/tb_stepper_profile_ctrl.sv
// Randomised bench for stepper_profile_ctrl: a step-level trapezoid model predicts step count,
// edge spacing, positions and completion for moves, aborts, homing, limit faults and reset.
module tb_stepper_profile_ctrl;
  localparam int POS_W = 16, DLY_W = 12, PW = 5, SD = 100, AS = 10, HD = 20;

  logic             clk = 1'b0, reset = 1'b1;
  logic             cmd_valid = 1'b0, home_req = 1'b0, abort = 1'b0, limit_sw = 1'b0;
  logic [POS_W-1:0] cmd_target = '0;
  logic [DLY_W-1:0] cmd_min_delay = '0;
  logic             cmd_ready, step, dir, busy, done, homed, lim_fault;
  logic [POS_W-1:0] position;

  stepper_profile_ctrl #(.POS_W(POS_W), .DLY_W(DLY_W), .PULSE_W(PW), .START_DELAY(SD),
                         .ACCEL_STEP(AS), .HOME_DELAY(HD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_min_delay(cmd_min_delay), .home_req(home_req),
    .abort(abort), .limit_sw(limit_sw), .step(step), .dir(dir), .position(position),
    .busy(busy), .done(done), .homed(homed), .lim_fault(lim_fault));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, model_pos = 0, done_cnt = 0, hi_len = 0;
  logic step_prev = 1'b0;
  int rise_t[$], rise_pos[$], widths[$];
  int exp_ivl[$], exp_ramp[$], exp_gap[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step && !step_prev) begin
      rise_t.push_back(cyc);
      rise_pos.push_back(int'(position));
    end
    if (step) hi_len++;
    else if (step_prev) begin
      widths.push_back(hi_len);
      hi_len = 0;
    end
    step_prev = step;
    if (done) done_cnt++;
  end

  task automatic clear_mon();
    rise_t.delete(); rise_pos.delete(); widths.delete();
    done_cnt = 0;
  endtask

  function automatic int clampm(input int m);
    if (m < PW + 1) return PW + 1;
    if (m > SD) return SD;
    return m;
  endfunction

  // Interval and ramp count established at each step of a d-step move (last step excluded).
  task automatic build_model(input int d, input int m);
    int i, r;
    exp_ivl.delete(); exp_ramp.delete();
    i = SD; r = 0;
    for (int k = 1; k < d; k++) begin
      if (d - k <= r) begin i = (i + AS > SD) ? SD : i + AS; r--; end
      else if (i > m) begin i = (i - AS < m) ? m : i - AS; r++; end
      exp_ivl.push_back(i);
      exp_ramp.push_back(r);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); #1; n++; end
    checks++;
    if (done_cnt == 0) begin failures++; $display("FAIL %s timeout: done never seen in %0d cycles", nm, budget); end
  endtask

  task automatic wait_rises(input int k);
    int n = 0;
    while (rise_t.size() < k && n < 5000) begin @(negedge clk); #1; n++; end
  endtask

  task automatic run_move(input string nm, input int tgt, input int mind, input int abort_k);
    int start, d, dn, nexp, acc, g, p;
    start = model_pos;
    dn = (tgt < start) ? 1 : 0;
    d = dn ? start - tgt : tgt - start;
    build_model(d, clampm(mind));
    exp_gap.delete();
    if (abort_k < 0) begin
      nexp = d;
      foreach (exp_ivl[j]) exp_gap.push_back(exp_ivl[j]);
    end else if (abort_k == 0) begin
      nexp = 0;
    end else begin
      nexp = abort_k + exp_ramp[abort_k-1];
      for (int j = 0; j < abort_k - 1; j++) exp_gap.push_back(exp_ivl[j]);
      g = exp_ivl[abort_k-1];
      for (int j = abort_k; j < nexp; j++) begin
        exp_gap.push_back(g);
        g = (g + AS > SD) ? SD : g + AS;
      end
    end
    @(negedge clk); clear_mon();
    cmd_valid = 1'b1; cmd_target = POS_W'(tgt); cmd_min_delay = DLY_W'(mind);
    @(posedge clk); #1; acc = cyc; cmd_valid = 1'b0;
    if (d != 0) begin
      checks++;
      if (dir !== dn[0]) begin failures++; $display("FAIL %s dir_setup: got %b want %0d", nm, dir, dn); end
    end
    if (abort_k == 0) begin
      abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    end else if (abort_k > 0) begin
      wait_rises(abort_k);
      abort = 1'b1; @(negedge clk); #1; abort = 1'b0;
    end
    wait_done(nm, 20000);
    repeat (8) @(negedge clk); #1;
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL %s done_pulses: got %0d want 1", nm, done_cnt); end
    checks++;
    if (rise_t.size() !== nexp) begin failures++; $display("FAIL %s step_count: got %0d want %0d", nm, rise_t.size(), nexp); end
    if (nexp > 0 && rise_t.size() > 0) begin
      checks++;
      if (rise_t[0] - acc !== 2) begin failures++; $display("FAIL %s first_step_latency: got %0d want 2", nm, rise_t[0] - acc); end
    end
    for (int j = 1; j < rise_t.size() && j < nexp; j++) begin
      checks++;
      if (rise_t[j] - rise_t[j-1] !== exp_gap[j-1]) begin
        failures++; $display("FAIL %s gap[%0d]: got %0d want %0d", nm, j, rise_t[j] - rise_t[j-1], exp_gap[j-1]);
      end
    end
    for (int j = 0; j < rise_pos.size() && j < nexp; j++) begin
      p = (dn ? start - (j + 1) : start + (j + 1)) & 16'hFFFF;
      checks++;
      if (rise_pos[j] !== p) begin failures++; $display("FAIL %s pos_at_step[%0d]: got %0d want %0d", nm, j, rise_pos[j], p); end
    end
    foreach (widths[j]) begin
      checks++;
      if (widths[j] !== PW) begin failures++; $display("FAIL %s pulse_width[%0d]: got %0d want %0d", nm, j, widths[j], PW); end
    end
    model_pos = (dn ? start - nexp : start + nexp) & 16'hFFFF;
    checks++;
    if (int'(position) !== model_pos) begin failures++; $display("FAIL %s final_pos: got %0d want %0d", nm, position, model_pos); end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL %s idle_after: busy=%b cmd_ready=%b want 0/1", nm, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({step, dir, busy, done, homed, lim_fault} !== 6'b0 || position !== '0) begin
      failures++; $display("FAIL reset_outputs: got step=%b dir=%b busy=%b done=%b homed=%b lf=%b pos=%0d want all 0",
                           step, dir, busy, done, homed, lim_fault, position);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_random_moves();
    for (int n = 0; n < 6; n++)
      run_move("rand_move", int'($urandom_range(0, 30)), int'($urandom_range(0, 150)), -1);
  endtask

  task automatic test_abort();
    run_move("abort_cruise", model_pos + 1000, 60, 6);
    run_move("abort_no_ramp", model_pos + 1000, 60, 0);
    run_move("abort_rand", model_pos + 1000, int'($urandom_range(0, 150)), int'($urandom_range(1, 12)));
  endtask

  task automatic test_home_late();
    int start, acc;
    start = model_pos;
    @(negedge clk); clear_mon(); home_req = 1'b1;
    @(posedge clk); #1; acc = cyc; home_req = 1'b0;
    checks++;
    if (dir !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL home_entry: dir=%b busy=%b want 1/1", dir, busy); end
    wait_rises(7);
    limit_sw = 1'b1;
    wait_done("home_late", 5000);
    repeat (5) @(negedge clk); #1;
    checks++;
    if (rise_t.size() !== 7) begin failures++; $display("FAIL home_steps: got %0d want 7", rise_t.size()); end
    if (rise_t.size() > 0) begin
      checks++;
      if (rise_t[0] - acc !== 2) begin failures++; $display("FAIL home_latency: got %0d want 2", rise_t[0] - acc); end
    end
    for (int j = 1; j < rise_t.size(); j++) begin
      checks++;
      if (rise_t[j] - rise_t[j-1] !== HD) begin failures++; $display("FAIL home_gap[%0d]: got %0d want %0d", j, rise_t[j] - rise_t[j-1], HD); end
    end
    foreach (rise_pos[j]) begin
      checks++;
      if (rise_pos[j] !== ((start - j - 1) & 16'hFFFF)) begin
        failures++; $display("FAIL home_pos[%0d]: got %0d want %0d", j, rise_pos[j], (start - j - 1) & 16'hFFFF);
      end
    end
    checks++;
    if (position !== '0 || homed !== 1'b1 || done_cnt !== 1) begin
      failures++; $display("FAIL home_done: pos=%0d homed=%b dones=%0d want 0/1/1", position, homed, done_cnt);
    end
    limit_sw = 1'b0; repeat (4) @(negedge clk);
    model_pos = 0;
  endtask

  task automatic test_home_limit_high();
    limit_sw = 1'b1; repeat (4) @(negedge clk);
    clear_mon(); home_req = 1'b1;
    @(posedge clk); #1; home_req = 1'b0;
    wait_done("home_high", 200);
    repeat (5) @(negedge clk); #1;
    checks++;
    if (rise_t.size() !== 0 || position !== '0 || homed !== 1'b1 || done_cnt !== 1) begin
      failures++; $display("FAIL home_limit_high: steps=%0d pos=%0d homed=%b dones=%0d want 0/0/1/1",
                           rise_t.size(), position, homed, done_cnt);
    end
    limit_sw = 1'b0; repeat (4) @(negedge clk);
    model_pos = 0;
  endtask

  task automatic test_lim_fault();
    int start;
    start = model_pos;
    @(negedge clk); clear_mon();
    cmd_valid = 1'b1; cmd_target = '0; cmd_min_delay = DLY_W'(60);
    @(posedge clk); #1; cmd_valid = 1'b0;
    wait_rises(3);
    limit_sw = 1'b1;
    wait_done("lim_fault", 2000);
    repeat (5) @(negedge clk); #1;
    checks++;
    if (rise_t.size() !== 3 || lim_fault !== 1'b1 || int'(position) !== start - 3 || done_cnt !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL lim_fault_stop: steps=%0d lf=%b pos=%0d dones=%0d busy=%b want 3/1/%0d/1/0",
                           rise_t.size(), lim_fault, position, done_cnt, busy, start - 3);
    end
    limit_sw = 1'b0; repeat (4) @(negedge clk);
    model_pos = start - 3;
    clear_mon();
    cmd_valid = 1'b1; cmd_target = POS_W'(model_pos);
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (4) @(negedge clk); #1;
    checks++;
    if (lim_fault !== 1'b0 || done_cnt !== 1 || rise_t.size() !== 0) begin
      failures++; $display("FAIL lim_fault_clear: lf=%b dones=%0d steps=%0d want 0/1/0", lim_fault, done_cnt, rise_t.size());
    end
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge clk); clear_mon();
    cmd_valid = 1'b1; cmd_target = POS_W'(model_pos + 5); cmd_min_delay = DLY_W'(60);
    @(posedge clk); #1; cmd_valid = 1'b0;
    wait_rises(1);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (step !== 1'b0 || busy !== 1'b0 || position !== '0 || homed !== 1'b0) begin
      failures++; $display("FAIL reset_mid_pulse: step=%b busy=%b pos=%0d homed=%b want 0/0/0/0", step, busy, position, homed);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_pos = 0;
    repeat (2) @(negedge clk);
    run_move("after_reset_same_pos", 0, 60, -1);
  endtask

  initial begin
    test_reset();
    run_move("move_0_20", 20, 60, -1);
    run_move("move_20_10", 10, 60, -1);
    run_move("move_10_0", 0, 60, -1);
    run_move("triangle_0_3", 3, 60, -1);
    test_random_moves();
    test_abort();
    test_home_late();
    run_move("move_to_12", 12, 40, -1);
    test_home_limit_high();
    run_move("move_to_30", 30, 30, -1);
    test_lim_fault();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
